iomem_arbiter: RTL and testbench

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

---
 rtl/iomem_arbiter_pkg.sv | 6 +
 rtl/iomem_arbiter_wdt.sv | 20 ++
 rtl/iomem_arbiter.sv | 83 ++++++++
 tb/tb_iomem_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/iomem_arbiter_pkg.sv
// iomem_arbiter_pkg: shared state encoding and constants for the iomem arbiter.
package iomem_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;
  localparam int TIMEOUT_CYCLES_DEF = 255;
endpackage

// File: rtl/iomem_arbiter_wdt.sv
// iomem_arbiter_wdt: per-transfer watchdog; expired flags the TIMEOUT_CYCLES-th busy cycle.
module iomem_arbiter_wdt
  import iomem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || start) cnt <= '0;
    else if (run) cnt <= cnt + 16'd1;
  end
  // cnt holds the number of busy cycles already elapsed, so the current cycle is cnt+1
  assign expired = run && (cnt == 16'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: two-requester round-robin arbiter onto one iomem slave.
// Optional per-transfer timeout enabled by defining IOMEM_ARBITER_TIMEOUT_EN.
module iomem_arbiter
  import iomem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);
  state_t state, state_nx;
  logic owner, rr, act, req, pick, sel_valid, done, to, fin, expired;
  logic [31:0] rdata;
  // outputs are silenced while rst is high, even mid-transfer
  assign act       = (state == BUSY) && !rst;
  assign req       = m0_valid || m1_valid;
  assign pick      = (m0_valid && m1_valid) ? rr : m1_valid;
  assign sel_valid = owner ? m1_valid : m0_valid;
  assign done      = sel_valid && s_ready;
  assign to        = sel_valid && !s_ready && expired;
  assign fin       = act && (done || to);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      rr    <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) owner <= pick;
      if (fin) rr <= !owner;
    end
  end
  always_comb begin
    state_nx = (state == IDLE) ? (req ? BUSY : IDLE)
                               : ((sel_valid && !done && !to) ? BUSY : IDLE);
  end
  always_comb begin
    grant    = act ? (owner ? 2'b10 : 2'b01) : 2'b00;
    s_valid  = act && sel_valid && !to;
    s_addr   = owner ? m1_addr : m0_addr;
    s_wdata  = owner ? m1_wdata : m0_wdata;
    s_wstrb  = owner ? m1_wstrb : m0_wstrb;
    m0_ready = fin && !owner;
    m1_ready = fin && owner;
    rdata    = done ? s_rdata : TIMEOUT_RDATA;
    m0_rdata = m0_ready ? rdata : '0;
    m1_rdata = m1_ready ? rdata : '0;
  end
`ifdef IOMEM_ARBITER_TIMEOUT_EN
  iomem_arbiter_wdt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdt (
    .clk(clk),
    .rst(rst),
    .start(!act && req),
    .run(act),
    .expired(expired)
  );
  always_ff @(posedge clk) timeout_err <= !rst && (timeout_err || (act && to));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter: table-driven vectors plus hand-written timeout/stall sequences.
module tb_iomem_arbiter;
  localparam logic [31:0] A0 = 32'h03000000;
  localparam logic [31:0] A1 = 32'h03000004;
  logic clk = 0, rst = 1;
  logic m0_valid = 0, m1_valid = 0, m0_ready, m1_ready, s_valid, s_ready = 0, timeout_err;
  logic [31:0] m0_addr = A0, m0_wdata = 32'h0000000F, m1_addr = A1, m1_wdata = 32'h0;
  logic [3:0] m0_wstrb = 4'hF, m1_wstrb = 4'h0, s_wstrb;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata = 0;
  logic [1:0] grant;
  int checks = 0, errors = 0, idx = 0;

  iomem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, v0, v1, sr;
    logic [31:0] srd;
    logic [1:0] g;
    logic sv;
    logic [31:0] sa;
    logic [3:0] sw;
    logic r0, r1;
    logic [31:0] rd0, rd1;
  } vec_t;
  vec_t vt[22];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", n, idx, a, e);
    end
  endtask

  task automatic cyc(input logic v0, input logic sr, input logic [31:0] srd);
    @(negedge clk);
    m0_valid = v0; s_ready = sr; s_rdata = srd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    //           rst v0 v1 sr srd            g     sv sa  sw    r0 r1 rd0           rd1
    vt[0]  = '{0, 1, 0, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[1]  = '{0, 1, 0, 0, 32'h0,         2'b01, 1, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[2]  = '{0, 1, 0, 1, 32'hAAAA5555,  2'b01, 1, A0, 4'hF, 1, 0, 32'hAAAA5555,  32'h0};
    vt[3]  = '{0, 0, 0, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[4]  = '{1, 0, 0, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[5]  = '{0, 1, 1, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[6]  = '{0, 1, 1, 1, 32'h11111111,  2'b01, 1, A0, 4'hF, 1, 0, 32'h11111111,  32'h0};
    vt[7]  = '{0, 1, 1, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[8]  = '{0, 1, 1, 1, 32'h12345678,  2'b10, 1, A1, 4'h0, 0, 1, 32'h0,         32'h12345678};
    vt[9]  = '{0, 1, 0, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[10] = '{0, 1, 0, 0, 32'h0,         2'b01, 1, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[11] = '{0, 0, 0, 0, 32'h0,         2'b01, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[12] = '{0, 1, 1, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[13] = '{0, 1, 1, 1, 32'h0,         2'b01, 1, A0, 4'hF, 1, 0, 32'h0,         32'h0};
    vt[14] = '{0, 0, 1, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[15] = '{0, 0, 1, 0, 32'h0,         2'b10, 1, A1, 4'h0, 0, 0, 32'h0,         32'h0};
    vt[16] = '{1, 1, 1, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[17] = '{0, 1, 1, 1, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[18] = '{0, 1, 1, 1, 32'hCAFEF00D,  2'b01, 1, A0, 4'hF, 1, 0, 32'hCAFEF00D,  32'h0};
    vt[19] = '{0, 0, 1, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    vt[20] = '{0, 0, 1, 1, 32'h0BADF00D,  2'b10, 1, A1, 4'h0, 0, 1, 32'h0,         32'h0BADF00D};
    vt[21] = '{0, 0, 0, 0, 32'h0,         2'b00, 0, A0, 4'hF, 0, 0, 32'h0,         32'h0};
    repeat (2) @(posedge clk);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      idx = i;
      rst = vt[i].rst; m0_valid = vt[i].v0; m1_valid = vt[i].v1;
      s_ready = vt[i].sr; s_rdata = vt[i].srd;
      #1;
      chk("grant", 32'(grant), 32'(vt[i].g));
      chk("s_valid", 32'(s_valid), 32'(vt[i].sv));
      if (vt[i].sv) begin
        chk("s_addr", s_addr, vt[i].sa);
        chk("s_wstrb", 32'(s_wstrb), 32'(vt[i].sw));
        chk("s_wdata", s_wdata, vt[i].sa == A0 ? 32'h0000000F : 32'h0);
      end
      chk("m0_ready", 32'(m0_ready), 32'(vt[i].r0));
      chk("m1_ready", 32'(m1_ready), 32'(vt[i].r1));
      chk("m0_rdata", m0_rdata, vt[i].rd0);
      chk("m1_rdata", m1_rdata, vt[i].rd1);
      chk("timeout_err", 32'(timeout_err), 32'h0);
    end
    idx = 100;
`ifdef IOMEM_ARBITER_TIMEOUT_EN
    do_reset();
    cyc(1, 0, 0);
    chk("to_idle_grant", 32'(grant), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 0, 0);
      idx = 100 + k;
      chk("to_m0_ready", 32'(m0_ready), 32'(k == 4));
      chk("to_s_valid", 32'(s_valid), 32'(k != 4));
      chk("to_err_pre", 32'(timeout_err), 32'h0);
      if (k == 4) chk("to_rdata", m0_rdata, 32'hDEADBEEF);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0);
      idx = 110 + k;
      chk("to_err_sticky", 32'(timeout_err), 32'h1);
      chk("to_grant_idle", 32'(grant), 32'h0);
      chk("to_m0_ready_off", 32'(m0_ready), 32'h0);
    end
    do_reset();
    idx = 120;
    chk("to_err_reset", 32'(timeout_err), 32'h0);
    cyc(1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) cyc(1, 1, 32'h5A5A5A5A);
      else cyc(1, 0, 0);
      idx = 120 + k;
      chk("win_m0_ready", 32'(m0_ready), 32'(k == 4));
      if (k == 4) chk("win_rdata", m0_rdata, 32'h5A5A5A5A);
    end
    cyc(0, 0, 0);
    idx = 130;
    chk("win_err", 32'(timeout_err), 32'h0);
    chk("win_grant", 32'(grant), 32'h0);
`else
    do_reset();
    cyc(1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 0, 0);
      idx = 100 + k;
      chk("stall_m0_ready", 32'(m0_ready), 32'h0);
      chk("stall_grant", 32'(grant), 32'h1);
      chk("stall_err", 32'(timeout_err), 32'h0);
    end
    cyc(1, 1, 32'h5A5A5A5A);
    idx = 130;
    chk("stall_done", 32'(m0_ready), 32'h1);
    chk("stall_rdata", m0_rdata, 32'h5A5A5A5A);
    cyc(0, 0, 0);
    chk("stall_err_end", 32'(timeout_err), 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
